// File: rtl/pc_stack_if.sv
// Request/load bus between the control decoder, the return-address stack and the PC.
// The decoder side drives requests (master); pc_stack answers with the PC load strobe and status (slave).
interface pc_stack_if;
  logic [7:0] pc;
  logic       call;
  logic       ret;
  logic       jump;
  logic [7:0] target;
  logic       PCincr;
  logic [7:0] data;
  logic       empty;
  logic       full;
  logic [4:0] depth;
  logic       err;

  modport master (
    output pc, call, ret, jump, target,
    input  PCincr, data, empty, full, depth, err
  );

  modport slave (
    input  pc, call, ret, jump, target,
    output PCincr, data, empty, full, depth, err
  );
endinterface

// File: rtl/pc_stack.sv
// Return-address stack and PC-load controller: decodes call/ret/jump into the PC load strobe and value.
// Optional feature: define PC_STACK_ERR_EN to build the sticky overflow/underflow error register.
module pc_stack #(
  parameter int DEPTH = 8
) (
  input logic        clk,
  input logic        reset_n,
  pc_stack_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_r [DEPTH];
  logic [CW-1:0] cnt_r;

  logic          empty_s;
  logic          full_s;
  logic [AW-1:0] top_s;
  logic [AW-1:0] wr_s;
  logic          ret_ok_s;
  logic          call_ok_s;
  logic          jump_ok_s;
  logic          pcincr_s;
  logic [7:0]    data_s;

  // Occupancy flags and the read/write slot indices derived from the entry count.
  always_comb begin
    empty_s = (cnt_r == {CW{1'b0}});
    full_s  = (cnt_r == CW'(DEPTH));
    top_s   = AW'(cnt_r - CW'(1'b1));
    wr_s    = AW'(cnt_r);
  end

  // Request decode with ret > call > jump priority; over/underflow and held reset fall back to increment.
  always_comb begin
    ret_ok_s  = reset_n & bus.ret & ~empty_s;
    call_ok_s = reset_n & ~bus.ret & bus.call & ~full_s;
    jump_ok_s = reset_n & ~bus.ret & ~bus.call & bus.jump;
    pcincr_s  = ~(ret_ok_s | call_ok_s | jump_ok_s);
    if (ret_ok_s) begin
      data_s = mem_r[top_s];
    end else begin
      data_s = bus.target;
    end
  end

  // Entry count: grows on an accepted call, shrinks on an accepted return.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (call_ok_s) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end else if (ret_ok_s) begin
      cnt_r <= cnt_r - CW'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Stack storage is deliberately not cleared by reset; only the count defines valid entries.
  always_ff @(posedge clk) begin
    if (call_ok_s) begin
      mem_r[wr_s] <= bus.pc + 8'd1;
    end
  end

`ifdef PC_STACK_ERR_EN
  logic err_r;
  logic fault_s;

  // A suppressed request is either a return on an empty stack or a call on a full one.
  always_comb begin
    fault_s = reset_n & ((bus.ret & empty_s) | (~bus.ret & bus.call & full_s));
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_r <= 1'b0;
    end else if (fault_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.PCincr = pcincr_s;
  assign bus.data   = data_s;
  assign bus.empty  = empty_s;
  assign bus.full   = full_s;
  assign bus.depth  = 5'(cnt_r);
endmodule

// File: tb/tb_pc_stack.sv
// Randomized plus directed bench for pc_stack against a queue-based return-stack model.
module tb_pc_stack;
  localparam int DEPTH = 8;
`ifdef PC_STACK_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  logic [7:0] stk[$];
  logic       m_err;

  pc_stack_if bus ();

  pc_stack #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_depth"}, 32'(bus.depth), 32'(stk.size()));
    chk({tag, "_empty"}, 32'(bus.empty), 32'(stk.size() == 0));
    chk({tag, "_full"},  32'(bus.full),  32'(stk.size() == DEPTH));
    chk({tag, "_err"},   32'(bus.err),   32'(m_err));
  endtask

  // One clock cycle: drive a request, check same-cycle outputs, advance model past the edge.
  task automatic do_cycle(input string tag, input logic c, input logic r, input logic j,
                          input logic [7:0] p, input logic [7:0] t);
    logic       e_inc;
    logic [7:0] e_data;
    int         act; // 0 none, 1 push, 2 pop, 3 fault
    bus.call = c; bus.ret = r; bus.jump = j; bus.pc = p; bus.target = t;
    #2;
    e_inc = 1'b1; e_data = t; act = 0;
    if (r) begin
      if (stk.size() > 0) begin e_inc = 1'b0; e_data = stk[$]; act = 2; end
      else act = 3;
    end else if (c) begin
      if (stk.size() < DEPTH) begin e_inc = 1'b0; act = 1; end
      else act = 3;
    end else if (j) begin
      e_inc = 1'b0;
    end
    chk({tag, "_PCincr"}, 32'(bus.PCincr), 32'(e_inc));
    chk({tag, "_data"},   32'(bus.data),   32'(e_data));
    check_status(tag);
    @(posedge clk);
    if (act == 1) stk.push_back(p + 8'd1);
    else if (act == 2) void'(stk.pop_back());
    else if (act == 3) m_err = ERR_ON;
    #1;
  endtask

  // Assert reset between edges with a call pending, check the immediate effect, release after an edge.
  task automatic rst_pulse(input string tag);
    bus.call = 1'b1; bus.ret = 1'b0; bus.jump = 1'b0;
    reset_n = 1'b0;
    stk.delete();
    m_err = 1'b0;
    #1;
    chk({tag, "_PCincr"}, 32'(bus.PCincr), 32'd1);
    chk({tag, "_data"},   32'(bus.data),   32'(bus.target));
    check_status(tag);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0; m_err = 1'b0;
    reset_n = 1'b0;
    bus.call = 1'b0; bus.ret = 1'b0; bus.jump = 1'b0;
    bus.pc = 8'h00; bus.target = 8'h42;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_depth",  32'(bus.depth),  32'd0);
    chk("rst_empty",  32'(bus.empty),  32'd1);
    chk("rst_full",   32'(bus.full),   32'd0);
    chk("rst_err",    32'(bus.err),    32'd0);
    chk("rst_PCincr", 32'(bus.PCincr), 32'd1);
    chk("rst_data",   32'(bus.data),   32'h42);
    reset_n = 1'b1;

    do_cycle("idle", 1'b0, 1'b0, 1'b0, 8'h00, 8'h42);
    do_cycle("call1", 1'b1, 1'b0, 1'b0, 8'h10, 8'h80);
    do_cycle("ret1", 1'b0, 1'b1, 1'b0, 8'h80, 8'h55);
    do_cycle("post1", 1'b0, 1'b0, 1'b0, 8'h81, 8'h00);

    do_cycle("nest_c0", 1'b1, 1'b0, 1'b0, 8'h05, 8'h20);
    do_cycle("nest_c1", 1'b1, 1'b0, 1'b0, 8'h20, 8'hFF);
    do_cycle("nest_c2", 1'b1, 1'b0, 1'b0, 8'hFF, 8'h30);
    do_cycle("nest_r0", 1'b0, 1'b1, 1'b0, 8'h30, 8'h01);
    do_cycle("nest_r1", 1'b0, 1'b1, 1'b0, 8'h00, 8'h02);
    do_cycle("nest_r2", 1'b0, 1'b1, 1'b0, 8'h21, 8'h03);
    do_cycle("jump", 1'b0, 1'b0, 1'b1, 8'h06, 8'h9A);

    for (int i = 0; i < DEPTH; i++) do_cycle("fill", 1'b1, 1'b0, 1'b0, 8'(8'h40 + i), 8'h10);
    do_cycle("ovf", 1'b1, 1'b0, 1'b0, 8'h77, 8'hC0);
    do_cycle("ovf_after", 1'b0, 1'b0, 1'b0, 8'h78, 8'hC1);
    for (int i = 0; i < DEPTH; i++) do_cycle("drain", 1'b0, 1'b1, 1'b0, 8'h00, 8'h11);

    do_cycle("udf", 1'b0, 1'b1, 1'b0, 8'h00, 8'h5A);
    do_cycle("push33", 1'b1, 1'b0, 1'b0, 8'h32, 8'h60);
    do_cycle("all3", 1'b1, 1'b1, 1'b1, 8'h60, 8'h70);
    do_cycle("all3_after", 1'b0, 1'b0, 1'b0, 8'h33, 8'h71);

    for (int i = 0; i < 3; i++) do_cycle("pre_rst", 1'b1, 1'b0, 1'b0, 8'(8'hA0 + i), 8'h90);
    rst_pulse("mid_rst");
    do_cycle("rst_udf", 1'b0, 1'b1, 1'b0, 8'h00, 8'h3C);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        bus.target = 8'($urandom);
        rst_pulse("rnd_rst");
      end else begin
        do_cycle("rnd",
                 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 35),
                 1'($urandom_range(0, 99) < 30),
                 8'($urandom), 8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
